// File: rtl/pe_seq_controller_pkg.sv
// Shared constants for the PE sequence controller.
// State encodings stay plain localparams so legacy tools can consume them.
package pe_seq_controller_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

endpackage

// File: rtl/pe_seq_controller_if.sv
// Handshake and datapath-control bundle between the layer sequencer and the PE controller.
interface pe_seq_controller_if #(
  parameter int unsigned CNT_WIDTH = 8
);

  logic                 i_valid;
  logic [CNT_WIDTH-1:0] cfg_len;
  logic                 i_abort;
  logic                 o_ready;
  logic                 pe_ready;
  logic                 pe_ack;
  logic                 cnt_en;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_first;
  logic                 cnt_last;
  logic                 pipe_en;
  logic                 o_valid;
  logic                 pe_busy;

  modport master (
    output i_valid, cfg_len, i_abort, o_ready,
    input  pe_ready, pe_ack, cnt_en, cnt, cnt_first, cnt_last, pipe_en, o_valid, pe_busy
  );

  modport slave (
    input  i_valid, cfg_len, i_abort, o_ready,
    output pe_ready, pe_ack, cnt_en, cnt, cnt_first, cnt_last, pipe_en, o_valid, pe_busy
  );

endinterface

// File: rtl/pe_valid_pipe.sv
// Valid-token shift register that mirrors a fixed-depth PE datapath.
// Shifts only when enabled; synchronous clear drops every token in flight.
module pe_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic inject,
  output logic valid_out,
  output logic any_valid
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (clr) begin
      pipe_d = '0;
    end else if (en) begin
      pipe_d = (pipe_q << 1) | DEPTH'(inject);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_out = pipe_q[DEPTH-1];
  assign any_valid = |pipe_q;

endmodule

// File: rtl/pe_seq_controller.sv
// PE sequence controller: accepts length-tagged operations, drives the iteration
// counter and first/last strobes, and tracks results through the datapath to o_valid.
module pe_seq_controller
  import pe_seq_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned PIPE_LATENCY = 3
) (
  input logic                clk,
  input logic                rst,
  pe_seq_controller_if.slave bus
);

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 busy, stall, last, ready, ack, inject, res_valid, any_valid;

  assign busy  = (state_q == StBusy);
  assign stall = res_valid & ~bus.o_ready;
  assign last  = busy & (cnt_q == len_q);
  assign ready = ~stall & ~bus.i_abort & (~busy | last);
  assign ack   = bus.i_valid & ready;
  // A token enters the datapath model on the final unstalled compute cycle.
  assign inject = last & ~stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (bus.i_abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (ack) begin
      state_d = StBusy;
      cnt_d   = '0;
      len_d   = bus.cfg_len;
    end else if (busy && !stall) begin
      if (last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  pe_valid_pipe #(
    .DEPTH (PIPE_LATENCY)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (~stall),
    .clr       (bus.i_abort),
    .inject    (inject),
    .valid_out (res_valid),
    .any_valid (any_valid)
  );

  assign bus.pe_ready  = ready;
  assign bus.pe_ack    = ack;
  assign bus.cnt_en    = busy & ~stall;
  assign bus.cnt       = cnt_q;
  assign bus.cnt_first = busy & (cnt_q == '0);
  assign bus.cnt_last  = last;
  assign bus.pipe_en   = ~stall;
  assign bus.o_valid   = res_valid;
  assign bus.pe_busy   = busy | any_valid;

endmodule

// File: doc/pe_seq_controller.md
Name: pe_seq_controller

Overview:
Parametrised successor to the single-shot PE control FSM. It owns the iteration counter, so callers no longer supply an external count-limit. Each accepted operation takes a run-time length, latched at accept, and first/last strobes mark the accumulator clear and commit. Completion is tracked through a PE datapath of fixed depth to a result valid, and downstream backpressure freezes the whole engine. It sits between the layer sequencer (upstream valid/ready) and a conv/PE datapath plus its output FIFO.

Parameters:
CNT_WIDTH, 8, width of iteration counter and cfg_len
PIPE_LATENCY, 3, cycles from last compute cycle to result at datapath output; legal range >= 1

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_valid  input  1  upstream request for a new operation
cfg_len  input  CNT_WIDTH  iteration count minus one; sampled only on pe_ack
i_abort  input  1  synchronous abort of all in-flight work
o_ready  input  1  downstream accepts result
pe_ready  output  1  controller can accept an operation this cycle
pe_ack  output  1  operation accepted this cycle
cnt_en  output  1  datapath compute enable for this cycle
cnt  output  CNT_WIDTH  index of element processed this cycle
cnt_first  output  1  cnt==0 while computing; accumulator clear
cnt_last  output  1  cnt==len while computing; accumulator commit
pipe_en  output  1  datapath pipeline advance enable (= ~stall)
o_valid  output  1  result valid at datapath output
pe_busy  output  1  BUSY or any result in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. On reset: state=IDLE, cnt=0, len_q=0, valid_pipe=0. All outputs are then 0 except pe_ready=1 and pipe_en=1.
- stall = o_valid & ~o_ready. pipe_en = ~stall.
- FSM has two states, IDLE and BUSY.
- pe_ready = ~stall & ~i_abort & (IDLE | (BUSY & cnt_last)).
- pe_ack = i_valid & pe_ready. Combinational, no dependence of i_valid on pe_ready.
- Accept is not a compute cycle:
  - On pe_ack: len_q <= cfg_len, cnt <= 0, state <= BUSY.
  - Compute starts the next cycle.
- In BUSY:
  - cnt_en = ~stall.
  - cnt_first = (cnt==0); cnt_last = (cnt==len_q).
  - When ~stall and ~cnt_last: cnt <= cnt+1.
  - When stall: cnt, state and len_q hold; cnt_first and cnt_last stay asserted as decoded, but cnt_en=0.
- Last cycle (BUSY & cnt_last & ~stall):
  - Inject a token into valid_pipe[0].
  - If pe_ack the same cycle (back-to-back): cnt <= 0, len_q <= cfg_len, stay BUSY. There are no idle bubbles between operations.
  - Otherwise state <= IDLE, cnt <= 0.
- In IDLE: cnt_en=0, cnt_first=0, cnt_last=0, cnt held at 0.
- cfg_len=0 gives a single compute cycle with cnt_first and cnt_last both high. cfg_len=2^CNT_WIDTH-1 gives 2^CNT_WIDTH cycles. No wrap-around occurs inside one operation.
- valid_pipe is a PIPE_LATENCY-bit shift register that shifts only when ~stall. o_valid = valid_pipe[PIPE_LATENCY-1].
- Latency: for a length L=len+1 op accepted at cycle t with no stall, o_valid is asserted at t+L+PIPE_LATENCY.
- Stall freezes the entire engine: counter, FSM and pipeline. This guarantees that no token is overwritten.
- pe_busy = BUSY | (|valid_pipe).
- i_abort (synchronous, highest priority over everything except rst):
  - next state=IDLE, cnt=0, valid_pipe=0.
  - pe_ready=0 and pe_ack=0 that cycle.
  - Outputs in the abort cycle itself are still decoded from current state.
- i_valid during stall or abort: not acknowledged. Upstream must hold the request.
- rst mid-operation: immediate return to the reset values. The pending result is discarded.

Decomposition:
- No shared package needed. State encodings are localparams.
- One natural sub-module: pe_valid_pipe (parametrised depth, shift enable, sync clear, inject). It is reusable for other pipelined PEs.

Test Plan:
- cfg_len=8, single i_valid pulse at cycle 10, o_ready=1 -> pe_ack@10; cnt_en 11..19 with cnt 0..8; cnt_first@11; cnt_last@19; o_valid@22 for 1 cycle; pe_busy 11..22.
- Two back-to-back ops (cfg_len=2, then 4) with i_valid held -> second pe_ack on first op's cnt_last cycle; cnt sequence 0,1,2,0,1,2,3,4 with no gap; o_valid pulses exactly 3 cycles after each cnt_last.
- cfg_len=0 -> cnt_first=cnt_last=1 on the same single compute cycle; o_valid 1+PIPE_LATENCY cycles after ack; cfg_len=255 -> 256 compute cycles, cnt ends at 255 with no wrap.
- o_ready=0 for 5 cycles while o_valid=1 and the next op is computing at cnt=3 -> cnt holds 3, cnt_en=0, pipe_en=0, pe_ready=0, o_valid held; on o_ready=1 counting resumes and no token is lost (2 o_valid pulses total).
- i_abort at cnt=4 with a token in valid_pipe[1] -> next cycle IDLE, cnt=0, o_valid never asserts, pe_busy=0, pe_ready=1.
- rst asserted asynchronously mid-BUSY (not clock-aligned) -> outputs reach their reset values before the next clk edge; the first op after rst release behaves as in scenario 1.
